// File: rtl/axi_demux_pkg.sv
// rtl/axi_demux_pkg.sv - shared types, limits and helpers for the registered 1xN stream demux
package axi_demux_pkg;

  // Upper bound on output channels; selects are widened to this range for checks.
  localparam int MAX_OUT   = 16;
  localparam int SEL_MAX_W = $clog2(MAX_OUT) + 1;

  // Routing state of the slave-side transaction.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  // True when sel addresses an existing output channel out of n.
  function automatic logic idx_valid(input logic [SEL_MAX_W-1:0] sel, input int n);
    return (int'(sel) < n);
  endfunction

endpackage

// File: rtl/axi_demux_out_slice.sv
// rtl/axi_demux_out_slice.sv - one-entry output register slice with zeroed payload when empty
module axi_demux_out_slice #(
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  input  logic              last,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] q,
  output logic              q_last
);

  logic [DATA_W-1:0] data_r;
  logic              last_r;

  // Hold one beat; a load in the same cycle as a drain replaces the entry without a bubble.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      valid  <= 1'b0;
      data_r <= '0;
      last_r <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      data_r <= d;
      last_r <= last;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end
  end

  // Idle channels present an all-zero payload so unselected outputs read clean.
  assign q      = valid ? data_r : '0;
  assign q_last = valid & last_r;

endmodule

// File: rtl/axi_demux_1xn_reg.sv
// rtl/axi_demux_1xn_reg.sv - registered 1-to-N stream demultiplexer with select lock and drop path
module axi_demux_1xn_reg
  import axi_demux_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [DATA_W-1:0]         s_data,
  input  logic [SEL_W-1:0]          s_sel,
  input  logic                      s_last,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [NUM_OUT*DATA_W-1:0] m_data,
  output logic [NUM_OUT-1:0]        m_last,
  output logic [NUM_OUT-1:0]        m_valid,
  input  logic [NUM_OUT-1:0]        m_ready,
  output logic                      busy,
  output logic                      err_pulse
);

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   lock_sel;
  logic [SEL_W-1:0]   lock_nxt;
  logic [SEL_W-1:0]   eff_sel;
  logic               sel_ok;
  logic               slot_full;
  logic               slot_ready;
  logic               accept;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] valid_nxt;

  // The select is only sampled on the first beat; continuation beats follow the lock.
  assign eff_sel = (state == IDLE) ? s_sel : lock_sel;
  assign sel_ok  = idx_valid(SEL_MAX_W'(eff_sel), NUM_OUT);

  // Look up the occupancy and downstream ready of the addressed slice.
  always_comb begin
    slot_full  = 1'b0;
    slot_ready = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (eff_sel == SEL_W'(i)) begin
        slot_full  = m_valid[i];
        slot_ready = m_ready[i];
      end
    end
  end

  // Dropped traffic is always sunk; routed traffic refills a slice as it drains.
  always_comb begin
    if ((state == DROP) || ((state == IDLE) && !sel_ok)) begin
      s_ready = 1'b1;
    end else begin
      s_ready = !slot_full || slot_ready;
    end
  end

  assign accept = s_valid && s_ready;

  // Steer an accepted beat into exactly one slice when the destination exists.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      load[i] = accept && sel_ok && (eff_sel == SEL_W'(i));
    end
  end

  // Slice occupancy after this edge, used to keep busy cycle-accurate.
  assign valid_nxt = load | (m_valid & ~m_ready);

  // Next-state logic: lock the destination on a multi-beat start, release on the last beat.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_sel;
    case (state)
      IDLE: begin
        if (accept && !s_last) begin
          lock_nxt  = s_sel;
          state_nxt = sel_ok ? ROUTE : DROP;
        end
      end
      ROUTE, DROP: begin
        if (accept && s_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, lock, error pulse and busy registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      lock_sel  <= '0;
      err_pulse <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_sel  <= lock_nxt;
      err_pulse <= accept && (state == IDLE) && !sel_ok;
      busy      <= (state_nxt != IDLE) || (|valid_nxt);
    end
  end

  // One register slice per output channel.
  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slice
    axi_demux_out_slice #(
      .DATA_W (DATA_W)
    ) u_slice (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .load    (load[g]),
      .d       (s_data),
      .last    (s_last),
      .valid   (m_valid[g]),
      .ready   (m_ready[g]),
      .q       (m_data[g*DATA_W +: DATA_W]),
      .q_last  (m_last[g])
    );
  end

endmodule

// File: tb/tb_axi_demux_1xn_reg.sv
// tb/tb_axi_demux_1xn_reg.sv - directed self-checking bench for the 1xN registered demux
module tb_axi_demux_1xn_reg;

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  // Four-output instance
  logic [31:0]  s_data4;
  logic [1:0]   s_sel4;
  logic         s_last4, s_valid4, s_ready4;
  logic [127:0] m_data4;
  logic [3:0]   m_last4, m_valid4, m_ready4;
  logic         busy4, err4;

  // Three-output instance (has an unused select code)
  logic [31:0]  s_data3;
  logic [1:0]   s_sel3;
  logic         s_last3, s_valid3, s_ready3;
  logic [95:0]  m_data3;
  logic [2:0]   m_last3, m_valid3, m_ready3;
  logic         busy3, err3;

  axi_demux_1xn_reg #(.NUM_OUT(4), .DATA_W(32)) u_dut4 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_data(s_data4), .s_sel(s_sel4), .s_last(s_last4), .s_valid(s_valid4), .s_ready(s_ready4),
    .m_data(m_data4), .m_last(m_last4), .m_valid(m_valid4), .m_ready(m_ready4),
    .busy(busy4), .err_pulse(err4)
  );

  axi_demux_1xn_reg #(.NUM_OUT(3), .DATA_W(32)) u_dut3 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_data(s_data3), .s_sel(s_sel3), .s_last(s_last3), .s_valid(s_valid3), .s_ready(s_ready3),
    .m_data(m_data3), .m_last(m_last3), .m_valid(m_valid3), .m_ready(m_ready3),
    .busy(busy3), .err_pulse(err3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rec(input int ch, input logic last, input logic [31:0] d);
    return {27'd0, 4'(ch), last, d};
  endfunction

  // Output handshakes of the four-output instance, in the order they complete.
  logic [63:0] rec_q[$];
  logic [63:0] exp_q[$];
  logic        err4_seen = 1'b0;

  always @(negedge ACLK) begin
    for (int i = 0; i < 4; i++) begin
      if (m_valid4[i] && m_ready4[i]) rec_q.push_back(rec(i, m_last4[i], m_data4[i*32 +: 32]));
    end
    if (err4) err4_seen <= 1'b1;
  end

  task automatic check_records(input string tag);
    int n;
    check($sformatf("%s_count", tag), 64'(rec_q.size()), 64'(exp_q.size()));
    n = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), rec_q[i], exp_q[i]);
    rec_q.delete();
    exp_q.delete();
  endtask

  // Present one beat on the four-output instance and wait (bounded) for its accept.
  task automatic send4(input logic [1:0] sel, input logic [31:0] data, input logic last, output int cycles);
    logic rdy;
    s_valid4 = 1'b1; s_sel4 = sel; s_data4 = data; s_last4 = last;
    cycles = 0;
    do begin
      @(negedge ACLK);
      rdy = s_ready4;
      @(posedge ACLK); #1;
      cycles++;
    end while (!rdy && cycles < 100);
    if (!rdy) check("send4_timeout", 64'(rdy), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int total;
    ARESETN = 1'b0;
    s_data4 = '0; s_sel4 = '0; s_last4 = 1'b0; s_valid4 = 1'b0; m_ready4 = '0;
    s_data3 = '0; s_sel3 = '0; s_last3 = 1'b0; s_valid3 = 1'b0; m_ready3 = '0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_mvalid4", 64'(m_valid4), 64'd0);
    check("rst_mdata4",  64'(|m_data4), 64'd0);
    check("rst_mlast4",  64'(m_last4),  64'd0);
    check("rst_busy4",   64'(busy4),    64'd0);
    check("rst_err4",    64'(err4),     64'd0);
    check("rst_mvalid3", 64'(m_valid3), 64'd0);
    ARESETN = 1'b1;
    check("idle_sready4", 64'(s_ready4), 64'd1);
    @(posedge ACLK); #1;

    // 1: single beat to channel 2
    m_ready4 = 4'b1111;
    rec_q.delete(); exp_q.delete();
    s_valid4 = 1'b1; s_sel4 = 2'd2; s_data4 = 32'hA5A5_0001; s_last4 = 1'b1;
    @(negedge ACLK);
    check("t1_sready",    64'(s_ready4), 64'd1);
    check("t1_mvalid_pre", 64'(m_valid4), 64'd0);
    @(posedge ACLK); #1;
    s_valid4 = 1'b0;
    @(negedge ACLK);
    check("t1_mvalid", 64'(m_valid4), 64'h4);
    check("t1_mlast",  64'(m_last4),  64'h4);
    check("t1_ch2",    64'(m_data4[95:64]),   64'hA5A5_0001);
    check("t1_ch0",    64'(m_data4[31:0]),    64'd0);
    check("t1_ch1",    64'(m_data4[63:32]),   64'd0);
    check("t1_ch3",    64'(m_data4[127:96]),  64'd0);
    check("t1_busy",   64'(busy4), 64'd1);
    @(negedge ACLK);
    check("t1_mvalid_after", 64'(m_valid4), 64'd0);
    check("t1_busy_after",   64'(busy4), 64'd0);
    @(posedge ACLK); #1;
    exp_q.push_back(rec(2, 1'b1, 32'hA5A5_0001));
    check_records("t1_rec");

    // 2: select locked for the whole burst
    send4(2'd1, 32'h2000_0000, 1'b0, c);
    send4(2'd3, 32'h2000_0001, 1'b0, c);
    send4(2'd3, 32'h2000_0002, 1'b0, c);
    send4(2'd3, 32'h2000_0003, 1'b1, c);
    s_valid4 = 1'b0;
    repeat (3) @(negedge ACLK);
    check("t2_busy_idle", 64'(busy4), 64'd0);
    @(posedge ACLK); #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(rec(1, i == 3, 32'h2000_0000 + 32'(i)));
    check_records("t2_rec");

    // 3: back-pressure on channel 0 for five cycles
    m_ready4 = 4'b1110;
    fork
      begin
        int cc;
        send4(2'd0, 32'h3000_0000, 1'b0, cc);
        send4(2'd0, 32'h3000_0001, 1'b0, cc);
        send4(2'd0, 32'h3000_0002, 1'b1, cc);
        s_valid4 = 1'b0;
      end
      begin
        @(negedge ACLK);
        check("t3_sready_empty", 64'(s_ready4), 64'd1);
        @(negedge ACLK);
        check("t3_sready_full",  64'(s_ready4), 64'd0);
        check("t3_mvalid_held",  64'(m_valid4), 64'd1);
        repeat (4) @(posedge ACLK);
        #1 m_ready4 = 4'b1111;
      end
    join
    repeat (3) @(negedge ACLK);
    check("t3_busy_idle", 64'(busy4), 64'd0);
    @(posedge ACLK); #1;
    for (int i = 0; i < 3; i++) exp_q.push_back(rec(0, i == 2, 32'h3000_0000 + 32'(i)));
    check_records("t3_rec");

    // 4: continuous 8-beat burst to channel 3
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send4(2'd3, 32'h4000_0000 + 32'(i), i == 7, c);
      total += c;
    end
    s_valid4 = 1'b0;
    check("t4_no_stall", 64'(total), 64'd8);
    @(negedge ACLK);
    check("t4_last_valid", 64'(m_valid4), 64'h8);
    check("t4_last_flag",  64'(m_last4),  64'h8);
    check("t4_last_data",  64'(m_data4[127:96]), 64'h4000_0007);
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #1;
    for (int i = 0; i < 8; i++) exp_q.push_back(rec(3, i == 7, 32'h4000_0000 + 32'(i)));
    check_records("t4_rec");

    // 5: invalid select on the three-output instance
    m_ready3 = 3'b111;
    s_valid3 = 1'b1; s_sel3 = 2'd3; s_data3 = 32'h5000_0000; s_last3 = 1'b0;
    @(negedge ACLK);
    check("t5_sready_b0", 64'(s_ready3), 64'd1);
    check("t5_err_pre",   64'(err3),     64'd0);
    @(posedge ACLK); #1;
    s_data3 = 32'h5000_0001; s_last3 = 1'b1; s_sel3 = 2'd0;
    @(negedge ACLK);
    check("t5_sready_b1", 64'(s_ready3), 64'd1);
    check("t5_err_pulse", 64'(err3),     64'd1);
    check("t5_busy_mid",  64'(busy3),    64'd1);
    check("t5_mvalid_b0", 64'(m_valid3), 64'd0);
    @(posedge ACLK); #1;
    s_valid3 = 1'b0;
    @(negedge ACLK);
    check("t5_err_cont",  64'(err3),     64'd0);
    check("t5_busy_end",  64'(busy3),    64'd0);
    check("t5_mvalid_b1", 64'(m_valid3), 64'd0);
    @(posedge ACLK); #1;
    s_valid3 = 1'b1; s_sel3 = 2'd3; s_data3 = 32'h5000_0002; s_last3 = 1'b1;
    @(negedge ACLK);
    check("t5s_sready", 64'(s_ready3), 64'd1);
    @(posedge ACLK); #1;
    s_valid3 = 1'b0;
    @(negedge ACLK);
    check("t5s_err",    64'(err3),     64'd1);
    check("t5s_busy",   64'(busy3),    64'd0);
    check("t5s_mvalid", 64'(m_valid3), 64'd0);
    @(negedge ACLK);
    check("t5s_err_off", 64'(err3), 64'd0);
    @(posedge ACLK); #1;
    s_valid3 = 1'b1; s_sel3 = 2'd2; s_data3 = 32'h5000_0003; s_last3 = 1'b1;
    @(posedge ACLK); #1;
    s_valid3 = 1'b0;
    @(negedge ACLK);
    check("t5v_mvalid", 64'(m_valid3), 64'h4);
    check("t5v_mlast",  64'(m_last3),  64'h4);
    check("t5v_data",   64'(m_data3[95:64]), 64'h5000_0003);
    check("t5v_err",    64'(err3), 64'd0);
    @(posedge ACLK); #1;

    // 6: reset in the middle of a burst to channel 1
    m_ready4 = 4'b1111;
    send4(2'd1, 32'h6000_0000, 1'b0, c);
    send4(2'd1, 32'h6000_0001, 1'b0, c);
    m_ready4 = 4'b1101;
    s_valid4 = 1'b1; s_sel4 = 2'd1; s_data4 = 32'h6000_0002; s_last4 = 1'b0;
    @(negedge ACLK);
    check("t6_mvalid_pre", 64'(m_valid4), 64'h2);
    check("t6_busy_pre",   64'(busy4),    64'd1);
    check("t6_sready_pre", 64'(s_ready4), 64'd0);
    #1 ARESETN = 1'b0;
    #1;
    check("t6_mvalid_rst", 64'(m_valid4), 64'd0);
    check("t6_busy_rst",   64'(busy4),    64'd0);
    check("t6_mdata_rst",  64'(|m_data4), 64'd0);
    s_valid4 = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    m_ready4 = 4'b1111;
    @(posedge ACLK); #1;
    send4(2'd0, 32'h6100_0000, 1'b0, c);
    send4(2'd1, 32'h6100_0001, 1'b1, c);
    s_valid4 = 1'b0;
    repeat (3) @(negedge ACLK);
    check("t6_busy_end", 64'(busy4), 64'd0);
    @(posedge ACLK); #1;
    exp_q.push_back(rec(1, 1'b0, 32'h6000_0000));
    exp_q.push_back(rec(0, 1'b0, 32'h6100_0000));
    exp_q.push_back(rec(0, 1'b1, 32'h6100_0001));
    check_records("t6_rec");

    check("err4_never", 64'(err4_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_demux_1xn_reg.md
Name: axi_demux_1xn_reg

Overview:
- Parametrised, registered 1-to-N stream demultiplexer for the AXI interconnect datapath.
- Routes a valid/ready payload stream, such as W beats or R beats, to one of NUM_OUT master-side channels.
- The route is chosen on a transaction's first beat and held until its last beat.
- Each output has a one-entry register slice. Throughput is one beat per cycle with full back-pressure.
- An out-of-range select drains the transaction internally and flags an error, so the bus never hangs.

Parameters:
- NUM_OUT, 4: number of output channels; legal range 2..16.
- DATA_W, 32: payload width in bits.
- SEL_W, $clog2(NUM_OUT): select width. Derived; do not override.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  slave-side payload.
- s_sel  in  SEL_W  destination index. Sampled only on the first beat of a transaction.
- s_last  in  1  marks the final beat of the transaction.
- s_valid  in  1  slave-side valid.
- s_ready  out  1  slave-side ready.
- m_data  out  NUM_OUT*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- m_last  out  NUM_OUT  per-channel last.
- m_valid  out  NUM_OUT  per-channel valid.
- m_ready  in  NUM_OUT  per-channel ready.
- busy  out  1  high while state is not IDLE or any slice holds data.
- err_pulse  out  1  one-cycle registered pulse on the first beat of a dropped transaction.

Behaviour:
- Reset (ARESETN low, asynchronous):
  - state goes to IDLE; lock_sel = 0; all slices are emptied.
  - m_valid, m_last, m_data, err_pulse and busy are all 0.
  - Beats held in slices at reset are discarded; no partial delivery after reset.
- Accept: a beat is accepted when s_valid && s_ready.
- eff_sel:
  - In IDLE, eff_sel = s_sel.
  - In ROUTE or DROP, eff_sel = lock_sel.
- Invalid select: eff_sel is invalid when it is >= NUM_OUT. This can only happen when NUM_OUT is not a power of two.
- s_ready:
  - In DROP, or in IDLE with an invalid eff_sel: s_ready = 1.
  - Otherwise: s_ready = !full[eff_sel] || m_ready[eff_sel]. This gives pass-through refill with no bubble.
  - s_ready never depends on s_valid.
- FSM transitions:
  - IDLE, accepted beat with s_last=0: latch lock_sel = s_sel. Go to ROUTE if the select is valid, else DROP.
  - IDLE, accepted beat with s_last=1: single-beat transaction; stay in IDLE and latch nothing.
  - ROUTE or DROP, accepted beat with s_last=1: go to IDLE.
  - A change in s_sel while in ROUTE or DROP is ignored.
- Slice i:
  - Loads {s_data, s_last} on accept when eff_sel == i and the select is valid. m_valid[i] rises the next cycle, so latency is 1 cycle.
  - Empties when m_valid[i] && m_ready[i] and no new load happens in that cycle.
  - Simultaneous drain and load keeps m_valid[i] = 1 with the new data.
  - m_data and m_last for channel i are forced to 0 whenever m_valid[i] = 0. Non-selected channels therefore read zero.
- Ordering: only one channel loads per cycle. Slices for different channels drain independently, and output-side ordering across channels is not guaranteed.
- Drop: beats accepted in DROP, or single-beat transactions with an invalid select, are consumed with no output.
- err_pulse: asserted the cycle after the first accepted beat of an invalid-select transaction. It is never asserted for continuation beats.
- busy: registered; equals (state != IDLE) || |m_valid.
- No combinational path from m_ready to m_valid. There is a combinational path from m_ready to s_ready by design.

Decomposition:
- Package axi_demux_pkg:
  - state enum {IDLE, ROUTE, DROP}, 2 bits.
  - constant MAX_OUT = 16.
  - function idx_valid(sel, n).
- Sub-module axi_demux_out_slice: one-entry register slice.
  - Parameter DATA_W.
  - Ports: ACLK, ARESETN, load, d, last, valid, ready, q, q_last.
  - Instantiated NUM_OUT times through a generate loop.

Test Plan:
1. Single-beat routing: NUM_OUT=4; send s_sel=2, s_data=0xA5A5_0001, s_last=1, all m_ready=1 → m_valid=4'b0100 exactly one cycle later; channel 2 data = 0xA5A5_0001 with m_last[2]=1; channels 0, 1 and 3 data = 0.
2. Select lock across a burst: 4-beat burst with s_sel=1 on beat 0, then s_sel driven to 3 on beats 1-3 → all 4 beats appear only on channel 1, in order, with m_last[1] on beat 4; state returns to IDLE.
3. Back-pressure: m_ready[0]=0 for 5 cycles during a 3-beat burst to channel 0 → s_ready low after the slice fills; no beat lost or duplicated; back-to-back delivery resumes once m_ready[0]=1.
4. Full throughput: continuous 8-beat burst with m_ready=1 → s_ready stays high; one beat per cycle on the output; last beat appears 1 cycle after its accept.
5. Invalid select: NUM_OUT=3; 2-beat burst with s_sel=3 → s_ready=1 on both beats; m_valid stays 0; exactly one err_pulse, the cycle after beat 0; busy falls after the last beat.
6. Reset mid-burst: ARESETN low after beat 2 of a 4-beat burst to channel 1 → m_valid=0 and busy=0 immediately. After release, a new transaction with s_sel=0 routes to channel 0, proving lock_sel was cleared.
